msu_core: RTL and testbench



---
 rtl/msu_pkg.sv | 26 ++
 rtl/msu_if.sv | 35 +++
 rtl/modular_square.sv | 70 +++++++
 rtl/msu_core.sv | 169 ++++++++++++++++
 tb/tb_msu_core.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msu_pkg.sv
// rtl/msu_pkg.sv - shared constants, transfer counts and FSM states for msu_core
package msu_pkg;

  localparam int AXI_LEN = 32;
  localparam int T_LEN   = 64;

  // Two t words each way; the input value stream always carries one trailing beat
  // past the value limbs, whose payload lands on discarded limbs.
  function automatic int in_xfers(input int nonredundant);
    return 2 * T_LEN / AXI_LEN + nonredundant / 2 + 1;
  endfunction

  function automatic int out_xfers(input int num_elements);
    return 2 + num_elements;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_SQUARE,
    ST_XFER,
    ST_SEND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/msu_if.sv
// rtl/msu_if.sv - host-facing job control and AXI-Stream bundle of msu_core
interface msu_if;
  import msu_pkg::*;

  logic               ap_start;
  logic               ap_done;
  logic               start_xfer;

  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [AXI_LEN-1:0] s_axis_tdata;
  logic [3:0]         s_axis_tkeep;
  logic               s_axis_tlast;
  logic [31:0]        s_axis_xfer_size_in_bytes;

  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [AXI_LEN-1:0] m_axis_tdata;
  logic [3:0]         m_axis_tkeep;
  logic               m_axis_tlast;
  logic [31:0]        m_axis_xfer_size_in_bytes;

  modport master (
    output ap_start, s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    input  ap_done, start_xfer, s_axis_tready, s_axis_xfer_size_in_bytes,
           m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_xfer_size_in_bytes
  );

  modport slave (
    input  ap_start, s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    output ap_done, start_xfer, s_axis_tready, s_axis_xfer_size_in_bytes,
           m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_xfer_size_in_bytes
  );

endinterface

// File: rtl/modular_square.sv
// rtl/modular_square.sv - two-stage y^2 mod (2^VLEN - 1) core over redundant limbs
module modular_square #(
  parameter int NONREDUNDANT_ELEMENTS = 8,
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NUM_ELEMENTS          = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
  parameter int WORD_LEN              = 16,
  parameter int BIT_LEN               = WORD_LEN + 1,
  parameter logic [NONREDUNDANT_ELEMENTS*WORD_LEN-1:0] MODULUS = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BIT_LEN-1:0] sq_in  [NUM_ELEMENTS],
  output logic [BIT_LEN-1:0] sq_out [NUM_ELEMENTS],
  output logic               valid
);

  localparam int VLEN = NONREDUNDANT_ELEMENTS * WORD_LEN;
  localparam int PLEN = 2 * VLEN;

  // For an all-ones modulus, 2^VLEN == 1, so folding the halves together reduces.
  function automatic logic [VLEN-1:0] fold_mod(input logic [PLEN-1:0] x);
    logic [VLEN:0]   s;
    logic [VLEN-1:0] r;
    s = {1'b0, x[VLEN-1:0]} + {1'b0, x[PLEN-1:VLEN]};
    r = s[VLEN-1:0] + VLEN'(s[VLEN]);
    return (r == MODULUS) ? '0 : r;
  endfunction

  logic [PLEN-1:0] w_in_wide;
  logic [VLEN-1:0] w_in_val;
  logic [PLEN-1:0] r_prod;
  logic            r_stage;
  logic [VLEN-1:0] r_res;
  logic            r_valid;

  always_comb begin
    w_in_wide = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++)
      w_in_wide = w_in_wide + (PLEN'(sq_in[i]) << (i * WORD_LEN));
  end

  assign w_in_val = fold_mod(w_in_wide);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prod  <= '0;
      r_stage <= 1'b0;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_stage <= start;
      r_valid <= r_stage;
      if (start)
        r_prod <= PLEN'(w_in_val) * PLEN'(w_in_val);
      if (r_stage)
        r_res <= fold_mod(r_prod);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ELEMENTS; i++)
      sq_out[i] = '0;
    for (int i = 0; i < NONREDUNDANT_ELEMENTS; i++)
      sq_out[i] = BIT_LEN'(r_res[i*WORD_LEN +: WORD_LEN]);
  end

  assign valid = r_valid;

endmodule

// File: rtl/msu_core.sv
// rtl/msu_core.sv - VDF modular squaring shell: receive job, iterate squarings, stream result
module msu_core
  import msu_pkg::*;
#(
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = 8,
  parameter int NUM_ELEMENTS          = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
  parameter int WORD_LEN              = 16,
  parameter int BIT_LEN               = WORD_LEN + 1,
  parameter logic [NONREDUNDANT_ELEMENTS*WORD_LEN-1:0] MODULUS = '1
) (
  input  logic clk,
  input  logic reset,
  msu_if.slave bus
);

  localparam int IN_XFERS  = in_xfers(NONREDUNDANT_ELEMENTS);
  localparam int OUT_XFERS = out_xfers(NUM_ELEMENTS);
  localparam int BEAT_W    = 8;
  localparam int T_BEATS   = 2 * T_LEN / AXI_LEN;

  state_t             r_state;
  state_t             w_next;
  logic [BEAT_W-1:0]  r_beat;
  logic [T_LEN-1:0]   r_t;
  logic [T_LEN-1:0]   r_t_final;
  logic [BIT_LEN-1:0] r_y [NUM_ELEMENTS];
  logic [BIT_LEN-1:0] w_sq_out [NUM_ELEMENTS];
  logic               r_busy;
  logic               w_sq_start;
  logic               w_sq_valid;
  logic               w_recv_fire;
  logic               w_recv_last;
  logic               w_send_fire;
  logic               w_send_last;
  logic               w_t_done;
  logic               w_s_tready;
  logic               w_m_tvalid;
  logic               w_start_xfer;
  logic               w_ap_done;
  logic [AXI_LEN-1:0] w_tdata;

  assign w_recv_fire = (r_state == ST_RECV) && bus.s_axis_tvalid;
  assign w_recv_last = (r_beat == BEAT_W'(IN_XFERS - 1));
  assign w_send_fire = (r_state == ST_SEND) && bus.m_axis_tready;
  assign w_send_last = (r_beat == BEAT_W'(OUT_XFERS - 1));
  assign w_t_done    = (r_t >= r_t_final);
  assign w_sq_start  = (r_state == ST_SQUARE) && !r_busy && !w_t_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_s_tready   = 1'b0;
    w_m_tvalid   = 1'b0;
    w_start_xfer = 1'b0;
    w_ap_done    = 1'b0;
    case (r_state)
      ST_IDLE:   if (bus.ap_start) w_next = ST_RECV;
      ST_RECV: begin
        w_s_tready = 1'b1;
        if (w_recv_fire && w_recv_last) w_next = ST_SQUARE;
      end
      ST_SQUARE: if (!r_busy && w_t_done) w_next = ST_XFER;
      ST_XFER: begin
        w_start_xfer = 1'b1;
        w_next       = ST_SEND;
      end
      ST_SEND: begin
        w_m_tvalid = 1'b1;
        if (w_send_fire && w_send_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_ap_done = 1'b1;
        w_next    = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // t words are written straight into the iteration counter, so it already holds t_start
  // when the last input beat is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat    <= '0;
      r_t       <= '0;
      r_t_final <= '0;
      r_busy    <= 1'b0;
      for (int i = 0; i < NUM_ELEMENTS; i++)
        r_y[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_beat <= '0;
          r_busy <= 1'b0;
          if (bus.ap_start)
            for (int i = 0; i < NUM_ELEMENTS; i++)
              r_y[i] <= '0;
        end
        ST_RECV: if (w_recv_fire) begin
          r_beat <= w_recv_last ? '0 : r_beat + BEAT_W'(1);
          if (r_beat == BEAT_W'(0)) r_t[AXI_LEN-1:0]           <= bus.s_axis_tdata;
          if (r_beat == BEAT_W'(1)) r_t[T_LEN-1:AXI_LEN]       <= bus.s_axis_tdata;
          if (r_beat == BEAT_W'(2)) r_t_final[AXI_LEN-1:0]     <= bus.s_axis_tdata;
          if (r_beat == BEAT_W'(3)) r_t_final[T_LEN-1:AXI_LEN] <= bus.s_axis_tdata;
          for (int i = 0; i < NONREDUNDANT_ELEMENTS; i++)
            if (r_beat == BEAT_W'(T_BEATS + i / 2))
              r_y[i] <= BIT_LEN'((i % 2 == 1) ? bus.s_axis_tdata[31:16] : bus.s_axis_tdata[15:0]);
        end
        ST_SQUARE: begin
          if (w_sq_start)
            r_busy <= 1'b1;
          if (w_sq_valid) begin
            r_busy <= 1'b0;
            r_t    <= r_t + 64'd1;
            for (int i = 0; i < NUM_ELEMENTS; i++)
              r_y[i] <= w_sq_out[i];
          end
        end
        ST_XFER: r_beat <= '0;
        ST_SEND: if (w_send_fire) r_beat <= r_beat + BEAT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_tdata = '0;
    if (r_beat == BEAT_W'(0))
      w_tdata = r_t[AXI_LEN-1:0];
    else if (r_beat == BEAT_W'(1))
      w_tdata = r_t[T_LEN-1:AXI_LEN];
    for (int i = 0; i < NUM_ELEMENTS; i++)
      if (r_beat == BEAT_W'(i + 2))
        w_tdata = AXI_LEN'(r_y[i]);
  end

  modular_square #(
    .NONREDUNDANT_ELEMENTS(NONREDUNDANT_ELEMENTS),
    .REDUNDANT_ELEMENTS   (REDUNDANT_ELEMENTS),
    .NUM_ELEMENTS         (NUM_ELEMENTS),
    .WORD_LEN             (WORD_LEN),
    .BIT_LEN              (BIT_LEN),
    .MODULUS              (MODULUS)
  ) u_modular_square (
    .clk   (clk),
    .reset (reset),
    .start (w_sq_start),
    .sq_in (r_y),
    .sq_out(w_sq_out),
    .valid (w_sq_valid)
  );

  assign bus.ap_done                   = w_ap_done;
  assign bus.start_xfer                = w_start_xfer;
  assign bus.s_axis_tready             = w_s_tready;
  assign bus.s_axis_xfer_size_in_bytes = 32'(IN_XFERS * 4);
  assign bus.m_axis_tvalid             = w_m_tvalid;
  assign bus.m_axis_tdata              = w_tdata;
  assign bus.m_axis_tkeep              = 4'hF;
  assign bus.m_axis_tlast              = w_m_tvalid && w_send_last;
  assign bus.m_axis_xfer_size_in_bytes = 32'(OUT_XFERS * 4);

endmodule

// File: tb/tb_msu_core.sv
// tb/tb_msu_core.sv - randomized self-checking bench for msu_core against a y^2 mod M model
`timescale 1ns/1ps
module tb_msu_core;

  localparam int NR    = 8;
  localparam int IN_X  = 9;
  localparam int OUT_X = 12;
  localparam logic [127:0] M = {128{1'b1}};

  logic clk;
  logic rst_n;
  msu_if bus ();
  msu_core dut (.clk(clk), .reset(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int cnt_done, cnt_xfer, cnt_sq;
  logic [31:0] cap_data [OUT_X];
  logic        cap_last [OUT_X];
  int   cap_n, cap_hold_bad, cap_early, cap_lat;
  logic cap_timeout, cap_tail_valid;

  always @(negedge clk) begin
    if (bus.ap_done)     cnt_done++;
    if (bus.start_xfer)  cnt_xfer++;
    if (dut.w_sq_start)  cnt_sq++;
  end

  function automatic logic [127:0] model_y(input logic [63:0] ts, input logic [63:0] tf,
                                           input logic [127:0] y);
    logic [255:0] p;
    logic [127:0] r;
    r = y;
    if (tf > ts)
      for (longint unsigned k = 0; k < tf - ts; k++) begin
        p = {128'b0, r} * {128'b0, r};
        r = 128'(p % {128'b0, M});
      end
    return r;
  endfunction

  function automatic logic [31:0] exp_beat(input logic [63:0] ts, input logic [63:0] tf,
                                           input logic [127:0] y, input int k);
    logic [127:0] yf;
    logic [63:0]  t;
    yf = model_y(ts, tf, y);
    t  = (tf > ts) ? tf : ts;
    if (k == 0) return t[31:0];
    if (k == 1) return t[63:32];
    if (k - 2 < NR) return {16'b0, yf[16*(k-2) +: 16]};
    return 32'b0;
  endfunction

  task automatic send_job(input logic [63:0] ts, input logic [63:0] tf, input logic [127:0] y);
    logic [31:0] beats [IN_X];
    int i, cyc;
    beats[0] = ts[31:0];
    beats[1] = ts[63:32];
    beats[2] = tf[31:0];
    beats[3] = tf[63:32];
    for (int k = 0; k < NR / 2; k++) beats[4+k] = y[32*k +: 32];
    beats[IN_X-1] = $urandom;
    cap_timeout = 1'b0;
    cnt_done = 0; cnt_xfer = 0; cnt_sq = 0;
    @(negedge clk);
    bus.ap_start = 1'b1;
    cap_lat = 0;
    do begin
      @(negedge clk);
      cap_lat++;
    end while (!bus.s_axis_tready && cap_lat < 20);
    bus.ap_start = 1'b0;
    i = 0;
    cyc = 0;
    while (i < IN_X && cyc < 200) begin
      bus.s_axis_tvalid = ($urandom_range(0, 3) != 0);
      bus.s_axis_tdata  = beats[i];
      if (bus.s_axis_tvalid && bus.s_axis_tready) i++;
      @(negedge clk);
      cyc++;
    end
    bus.s_axis_tvalid = 1'b0;
    if (i < IN_X) cap_timeout = 1'b1;
  endtask

  task automatic recv_job(input int mode);
    int cyc;
    logic stalled;
    logic [31:0] held;
    cap_n = 0; cap_hold_bad = 0; cap_early = 0;
    stalled = 1'b0;
    held = '0;
    cyc = 0;
    while (cap_n < OUT_X && cyc < 20000) begin
      case (mode)
        0:       bus.m_axis_tready = 1'b1;
        1:       bus.m_axis_tready = cyc[0];
        default: bus.m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      if (bus.m_axis_tvalid && cnt_xfer == 0) cap_early++;
      if (stalled && (!bus.m_axis_tvalid || bus.m_axis_tdata !== held)) cap_hold_bad++;
      stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
      held    = bus.m_axis_tdata;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        cap_data[cap_n] = bus.m_axis_tdata;
        cap_last[cap_n] = bus.m_axis_tlast;
        cap_n++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.m_axis_tready = 1'b0;
    if (cap_n < OUT_X) cap_timeout = 1'b1;
    cap_tail_valid = bus.m_axis_tvalid;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.s_axis_xfer_size_in_bytes !== 32'd36) begin n_fail++;
      $display("FAIL reset_in_size got=%0d want=36", bus.s_axis_xfer_size_in_bytes); end
    n_checks++; if (bus.m_axis_xfer_size_in_bytes !== 32'd48) begin n_fail++;
      $display("FAIL reset_out_size got=%0d want=48", bus.m_axis_xfer_size_in_bytes); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({bus.s_axis_tready, bus.m_axis_tvalid, bus.start_xfer, bus.ap_done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle_outputs got=%b want=0000",
        {bus.s_axis_tready, bus.m_axis_tvalid, bus.start_xfer, bus.ap_done}); end
    n_checks++; if (bus.m_axis_tkeep !== 4'hF) begin n_fail++;
      $display("FAIL reset_tkeep got=%h want=f", bus.m_axis_tkeep); end
    n_checks++; if (bus.s_axis_xfer_size_in_bytes !== 32'd36) begin n_fail++;
      $display("FAIL idle_in_size got=%0d want=36", bus.s_axis_xfer_size_in_bytes); end
  endtask

  task automatic test_single();
    logic [31:0] want;
    send_job(64'd0, 64'd1, 128'd3);
    recv_job(0);
    n_checks++; if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout got=1 want=0"); end
    n_checks++; if (cap_lat !== 1) begin n_fail++; $display("FAIL single_tready_lat got=%0d want=1", cap_lat); end
    for (int k = 0; k < OUT_X; k++) begin
      want = (k == 0) ? 32'd1 : (k == 2) ? 32'd9 : 32'd0;
      n_checks++; if (cap_data[k] !== want) begin n_fail++;
        $display("FAIL single_beat%0d got=%h want=%h", k, cap_data[k], want); end
      n_checks++; if (cap_last[k] !== (k == OUT_X - 1)) begin n_fail++;
        $display("FAIL single_tlast%0d got=%b want=%b", k, cap_last[k], k == OUT_X - 1); end
    end
    n_checks++; if (cnt_done !== 1) begin n_fail++; $display("FAIL single_ap_done got=%0d want=1", cnt_done); end
    n_checks++; if (cnt_xfer !== 1) begin n_fail++; $display("FAIL single_start_xfer got=%0d want=1", cnt_xfer); end
    n_checks++; if (cnt_sq !== 1) begin n_fail++; $display("FAIL single_core_starts got=%0d want=1", cnt_sq); end
    n_checks++; if (cap_early !== 0) begin n_fail++; $display("FAIL single_early_tvalid got=%0d want=0", cap_early); end
    n_checks++; if (cap_tail_valid !== 1'b0) begin n_fail++; $display("FAIL single_tail_tvalid got=1 want=0"); end
  endtask

  task automatic test_three();
    logic [31:0] want;
    send_job(64'd5, 64'd8, 128'd2);
    recv_job(2);
    for (int k = 0; k < OUT_X; k++) begin
      want = (k == 0) ? 32'd8 : (k == 2) ? 32'h100 : 32'd0;
      n_checks++; if (cap_data[k] !== want) begin n_fail++;
        $display("FAIL three_beat%0d got=%h want=%h", k, cap_data[k], want); end
    end
    n_checks++; if (cnt_sq !== 3) begin n_fail++; $display("FAIL three_core_starts got=%0d want=3", cnt_sq); end
    n_checks++; if (cnt_done !== 1) begin n_fail++; $display("FAIL three_ap_done got=%0d want=1", cnt_done); end
  endtask

  task automatic test_reduction();
    logic [31:0] want;
    send_job(64'd0, 64'd1, 128'd1 << 64);
    recv_job(0);
    for (int k = 0; k < OUT_X; k++) begin
      want = (k == 0 || k == 2) ? 32'd1 : 32'd0;
      n_checks++; if (cap_data[k] !== want) begin n_fail++;
        $display("FAIL reduction_beat%0d got=%h want=%h", k, cap_data[k], want); end
    end
  endtask

  task automatic test_zero_iter();
    logic [31:0] want;
    send_job(64'd7, 64'd7, 128'h1234);
    recv_job(0);
    n_checks++; if (cnt_sq !== 0) begin n_fail++; $display("FAIL zero_core_starts got=%0d want=0", cnt_sq); end
    for (int k = 0; k < OUT_X; k++) begin
      want = (k == 0) ? 32'd7 : (k == 2) ? 32'h1234 : 32'd0;
      n_checks++; if (cap_data[k] !== want) begin n_fail++;
        $display("FAIL zero_beat%0d got=%h want=%h", k, cap_data[k], want); end
    end
    n_checks++; if (cnt_done !== 1) begin n_fail++; $display("FAIL zero_ap_done got=%0d want=1", cnt_done); end
  endtask

  task automatic test_toggle_ready();
    logic [127:0] y;
    logic [31:0]  want;
    int nlast;
    y = {$urandom, $urandom, $urandom, $urandom};
    send_job(64'd3, 64'd5, y);
    recv_job(1);
    nlast = 0;
    for (int k = 0; k < OUT_X; k++) begin
      want = exp_beat(64'd3, 64'd5, y, k);
      n_checks++; if (cap_data[k] !== want) begin n_fail++;
        $display("FAIL toggle_beat%0d got=%h want=%h", k, cap_data[k], want); end
      if (cap_last[k]) nlast++;
    end
    n_checks++; if (nlast !== 1 || cap_last[OUT_X-1] !== 1'b1) begin n_fail++;
      $display("FAIL toggle_tlast got=%0d/%b want=1/1", nlast, cap_last[OUT_X-1]); end
    n_checks++; if (cap_hold_bad !== 0) begin n_fail++; $display("FAIL toggle_hold got=%0d want=0", cap_hold_bad); end
    n_checks++; if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL toggle_timeout got=1 want=0"); end
  endtask

  task automatic test_random();
    logic [63:0]  ts, tf;
    logic [127:0] y;
    logic [31:0]  want;
    int exp_sq;
    for (int j = 0; j < 6; j++) begin
      if (j == 0) ts = 64'h0000_0000_FFFF_FFFE;
      else        ts = {32'($urandom_range(0, 32'hFFFF_FFF0)), $urandom};
      if (j % 3 == 2) tf = ts - 64'($urandom_range(0, 3));
      else            tf = ts + 64'($urandom_range(1, 4));
      y = {$urandom, $urandom, $urandom, $urandom};
      exp_sq = (tf > ts) ? int'(tf - ts) : 0;
      send_job(ts, tf, y);
      recv_job($urandom_range(0, 2));
      for (int k = 0; k < OUT_X; k++) begin
        want = exp_beat(ts, tf, y, k);
        n_checks++; if (cap_data[k] !== want) begin n_fail++;
          $display("FAIL random%0d_beat%0d got=%h want=%h", j, k, cap_data[k], want); end
      end
      n_checks++; if (cnt_sq !== exp_sq) begin n_fail++;
        $display("FAIL random%0d_core_starts got=%0d want=%0d", j, cnt_sq, exp_sq); end
      n_checks++; if (cap_hold_bad !== 0 || cnt_done !== 1) begin n_fail++;
        $display("FAIL random%0d_hold_done got=%0d/%0d want=0/1", j, cap_hold_bad, cnt_done); end
    end
  endtask

  task automatic test_reset_mid_square();
    logic [127:0] y;
    logic [31:0]  want;
    send_job(64'd0, 64'd5000, 128'h5);
    repeat (30) @(negedge clk);
    n_checks++; if (cnt_sq < 1) begin n_fail++; $display("FAIL midsq_started got=%0d want=>0", cnt_sq); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.s_axis_tready, bus.m_axis_tvalid, bus.start_xfer, bus.ap_done} !== 4'b0) begin
      n_fail++; $display("FAIL midsq_reset_outputs got=%b want=0000",
        {bus.s_axis_tready, bus.m_axis_tvalid, bus.start_xfer, bus.ap_done}); end
    n_checks++; if (bus.m_axis_xfer_size_in_bytes !== 32'd48) begin n_fail++;
      $display("FAIL midsq_out_size got=%0d want=48", bus.m_axis_xfer_size_in_bytes); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt_sq = 0; cnt_xfer = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (cnt_sq !== 0 || cnt_xfer !== 0 || bus.s_axis_tready !== 1'b0) begin n_fail++;
      $display("FAIL midsq_idle_after got=%0d/%0d/%b want=0/0/0", cnt_sq, cnt_xfer, bus.s_axis_tready); end
    y = {$urandom, $urandom, $urandom, $urandom};
    send_job(64'd2, 64'd4, y);
    recv_job(2);
    for (int k = 0; k < OUT_X; k++) begin
      want = exp_beat(64'd2, 64'd4, y, k);
      n_checks++; if (cap_data[k] !== want) begin n_fail++;
        $display("FAIL midsq_job_beat%0d got=%h want=%h", k, cap_data[k], want); end
    end
    n_checks++; if (cnt_done !== 1 || cnt_sq !== 2) begin n_fail++;
      $display("FAIL midsq_job_counts got=%0d/%0d want=1/2", cnt_done, cnt_sq); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.ap_start      = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = 4'hF;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_reduction();
    test_zero_iter();
    test_toggle_ready();
    test_random();
    test_reset_mid_square();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
